// File: rtl/regm_mp_if.sv
// Register-memory port bundle: decode-stage read addresses, two writeback
// ports, and the status/debug outputs returned by the memory.
interface regm_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 3
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic                    wa_en;
  logic [ADDR_W-1:0]       wa_addr;
  logic [DATA_W-1:0]       wa_data;
  logic                    wb_en;
  logic [ADDR_W-1:0]       wb_addr;
  logic [DATA_W-1:0]       wb_data;
  logic                    busy;
  logic [15:0]             dbg_out;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    input  rd_data, busy, dbg_out
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
    output rd_data, busy, dbg_out
  );
endinterface

// File: rtl/regm_mp.sv
// Parametrised multi-port register memory: NREAD combinational read ports
// with write bypass, two write ports (B wins on address clash), hardwired
// zero at address 0, a post-reset hardware clear sweep, and a debug tap.
module regm_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 3,
  parameter int DBG0   = 3,
  parameter int DBG1   = 8,
  parameter int DBG2   = 9,
  parameter int DBG3   = 11
) (
  input  logic      clk,
  input  logic      rst,
  regm_mp_if.slave  bus
);

  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DBG0_A = ADDR_W'(DBG0);
  localparam logic [ADDR_W-1:0] DBG1_A = ADDR_W'(DBG1);
  localparam logic [ADDR_W-1:0] DBG2_A = ADDR_W'(DBG2);
  localparam logic [ADDR_W-1:0] DBG3_A = ADDR_W'(DBG3);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy;
  // Entry 0 is never written; reads of address 0 are forced to zero.
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wa_ok;
  logic                w_wb_ok;
  logic [3:0]          w_nib0, w_nib1, w_nib2, w_nib3;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // Next state: sweep leaves CLEAR on the edge that clears the last entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_ptr == LAST) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Clear pointer: restarts at 1 on reset, stops at DEPTH-1 so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                                      r_ptr <= ONE;
    else if (r_state == S_CLEAR && r_ptr != LAST) r_ptr <= r_ptr + ONE;
  end

  // Registered busy flag mirrors the CLEAR state.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= 1'b1;
    else     r_busy <= (w_state_nxt == S_CLEAR);
  end

  // Port A is dropped when B targets the same address; address 0 is discarded.
  assign w_wa_ok = bus.wa_en && (bus.wa_addr != '0) &&
                   !(bus.wb_en && (bus.wb_addr == bus.wa_addr));
  assign w_wb_ok = bus.wb_en && (bus.wb_addr != '0);

  // Storage update: clear sweep in CLEAR, writeback ports in RUN, nothing under rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else begin
        if (w_wa_ok) r_mem[bus.wa_addr] <= bus.wa_data;
        if (w_wb_ok) r_mem[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  // Read ports: gated while busy, zero at address 0, B bypass over A over storage.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    // Per-port read mux in priority order.
    always_comb begin
      w_data = '0;
      if (r_busy || w_addr == '0)                   w_data = '0;
      else if (bus.wb_en && bus.wb_addr == w_addr)  w_data = bus.wb_data;
      else if (bus.wa_en && bus.wa_addr == w_addr)  w_data = bus.wa_data;
      else                                          w_data = r_mem[w_addr];
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = w_data;
  end

  // Debug tap shows stored contents only (no bypass); a tap on address 0 reads 0.
  assign w_nib0 = (DBG0_A == '0) ? 4'h0 : r_mem[DBG0_A][3:0];
  assign w_nib1 = (DBG1_A == '0) ? 4'h0 : r_mem[DBG1_A][3:0];
  assign w_nib2 = (DBG2_A == '0) ? 4'h0 : r_mem[DBG2_A][3:0];
  assign w_nib3 = (DBG3_A == '0) ? 4'h0 : r_mem[DBG3_A][3:0];

  assign bus.dbg_out = r_busy ? 16'h0000 : {w_nib0, w_nib1, w_nib2, w_nib3};
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_regm_mp.sv
// Bench for regm_mp: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the register file.
module tb_regm_mp;

  logic clk = 1'b0;
  logic rst;

  regm_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(3)) bus ();

  regm_mp #(
    .DATA_W(32), .ADDR_W(5), .NREAD(3),
    .DBG0(3), .DBG1(8), .DBG2(9), .DBG3(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: storage contents, busy flag, and remaining clear edges.
  logic [31:0] m_mem [32];
  logic        m_busy = 1'b1;
  int          m_left = 31;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (m_busy)                               return 32'h0;
    if (a == 5'd0)                            return 32'h0;
    if (bus.wb_en && bus.wb_addr == a)        return bus.wb_data;
    if (bus.wa_en && bus.wa_addr == a)        return bus.wa_data;
    return m_mem[a];
  endfunction

  function automatic logic [15:0] exp_dbg();
    if (m_busy) return 16'h0;
    return {m_mem[3][3:0], m_mem[8][3:0], m_mem[9][3:0], m_mem[11][3:0]};
  endfunction

  // One rising edge; the model absorbs the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1;
      m_left = 31;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      end
    end else begin
      if (bus.wa_en && bus.wa_addr != 5'd0) m_mem[bus.wa_addr] = bus.wa_data;
      if (bus.wb_en && bus.wb_addr != 5'd0) m_mem[bus.wb_addr] = bus.wb_data;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s rd%0d", tag, k), bus.rd_data[k*32 +: 32], exp_rd(bus.rd_addr[k*5 +: 5]));
    chk({tag, " busy"}, {31'b0, bus.busy}, {31'b0, m_busy});
    chk({tag, " dbg"}, {16'b0, bus.dbg_out}, {16'b0, exp_dbg()});
  endtask

  task automatic idle();
    bus.wa_en = 1'b0; bus.wa_addr = 5'd0; bus.wa_data = 32'h0;
    bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr = {a2, a1, a0};
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    bus.wa_en = 1'b1; bus.wa_addr = a; bus.wa_data = d;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  // Counts edges from rst low until busy drops, checking every cycle on the way.
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (bus.busy !== 1'b0 && cnt < 200) begin
      #2 check_all(tag);
      tick();
      cnt++;
    end
    chk({tag, " length"}, cnt, 32'd31);
  endtask

  task automatic check_all_zero(input string tag);
    idle();
    for (int a = 0; a < 32; a += 3) begin
      set_rd(5'(a), 5'((a + 1) % 32), 5'((a + 2) % 32));
      #2;
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s a%0d", tag, (a + k) % 32), bus.rd_data[k*32 +: 32], 32'h0);
      tick();
    end
    #2 chk({tag, " dbg"}, {16'b0, bus.dbg_out}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    rst = 1'b1;
    idle();
    set_rd(5'd0, 5'd1, 5'd2);

    // Reset held for two edges.
    tick(); tick();
    #2 check_all("reset");
    chk("reset busy", {31'b0, bus.busy}, 32'd1);
    chk("reset dbg", {16'b0, bus.dbg_out}, 32'h0);

    // Clear sweep, then every register reads zero.
    rst = 1'b0;
    wait_clear("clr1");
    check_all_zero("clr1 zero");

    // Basic writes on both ports.
    wr_a(5'd8, 32'hDEADBEEF);
    wr_b(5'd9, 32'h12345678);
    tick();
    idle();
    set_rd(5'd8, 5'd9, 5'd0);
    #2;
    chk("basic r8", bus.rd_data[31:0],  32'hDEADBEEF);
    chk("basic r9", bus.rd_data[63:32], 32'h12345678);
    chk("basic r0", bus.rd_data[95:64], 32'h0);
    chk("basic dbg", {16'b0, bus.dbg_out}, 32'h0F80);
    check_all("basic");

    // Same-address conflict: B wins, both in bypass and in storage.
    wr_a(5'd3, 32'h1111);
    wr_b(5'd3, 32'h2222);
    set_rd(5'd3, 5'd3, 5'd9);
    #2 chk("conflict bypass", bus.rd_data[31:0], 32'h2222);
    check_all("conflict");
    tick();
    idle();
    #2 chk("conflict stored", bus.rd_data[31:0], 32'h2222);
    chk("conflict dbg", {16'b0, bus.dbg_out}, 32'h2F80);

    // Bypass in the write cycle, and address 0 discards writes.
    wr_a(5'd11, 32'hA5);
    set_rd(5'd11, 5'd8, 5'd0);
    #2 chk("bypass r11", bus.rd_data[31:0], 32'hA5);
    check_all("bypass");
    tick();
    idle();
    wr_a(5'd0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd11, 5'd3);
    #2 chk("r0 bypass", bus.rd_data[31:0], 32'h0);
    chk("r11 stored", bus.rd_data[63:32], 32'hA5);
    tick();
    idle();
    #2 chk("r0 stored", bus.rd_data[31:0], 32'h0);

    // Writes attempted during clear are ignored.
    wr_a(5'd5, 32'h77);
    tick();
    rst = 1'b1;
    wr_a(5'd5, 32'h55);
    tick();
    rst = 1'b0;
    set_rd(5'd5, 5'd8, 5'd11);
    wait_clear("clr2");
    idle();
    #2 chk("clr2 r5", bus.rd_data[31:0], 32'h0);
    check_all("clr2");

    // Reset pulsed mid-clear restarts the full sweep.
    wr_a(5'd12, 32'hCAFE);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("clr3");
    check_all_zero("clr3 zero");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.wa_en   = $urandom_range(0, 1) == 1;
      bus.wa_addr = 5'($urandom_range(0, 31));
      bus.wa_data = $urandom;
      bus.wb_en   = $urandom_range(0, 1) == 1;
      bus.wb_addr = ($urandom_range(0, 3) == 0) ? bus.wa_addr : 5'($urandom_range(0, 31));
      bus.wb_data = $urandom;
      set_rd(($urandom_range(0, 3) == 0) ? bus.wa_addr : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0) ? bus.wb_addr : 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
      #2 check_all("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regm_mp.md
# regm_mp

Parametrised multi-port register memory for the new processor datapath. It replaces the fixed 32x32, three-read, one-write register file with configurable width, depth and read-port count, and adds a second write port with defined priority. It also adds a hardware clear sequence after reset, with a busy flag, and a configurable four-register debug tap for the board display. It sits between the decode stage (read addresses) and the writeback stage (write ports). Writeback B is intended for the scan/accelerator result path.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- NREAD, 3, number of read ports (1..8)
- DBG0, DBG1, DBG2, DBG3, 3 / 8 / 9 / 11, register addresses shown on the debug tap

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; starts the clear sequence
- rd_addr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- wa_en  in  1  write port A enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- busy  out  1  clear sequence in progress; writes ignored, reads return 0
- dbg_out  out  16  nibbles {mem[DBG0][3:0], mem[DBG1][3:0], mem[DBG2][3:0], mem[DBG3][3:0]}, MSB first

## Operation
State machine with two states:
- CLEAR
  - Entered on any edge where rst=1. ptr loads 1.
  - While rst=1, no entry is written and ptr holds at 1.
  - On each edge with rst=0, mem[ptr] <= 0 and ptr increments.
  - On the edge where ptr == DEPTH-1 (and rst=0), the last entry is cleared and the state goes to RUN.
- RUN
  - Normal operation. The only exit is rst=1, which returns the state to CLEAR, including mid-operation.

busy:
- busy = (state == CLEAR). It is a registered output, reset value 1.

Address 0:
- Never stored. Reads of address 0 always return 0; writes to address 0 are discarded.

Writes (RUN only):
- At an edge, each enabled port writes its data to its nonzero address.
- If wa_addr == wb_addr with both enabled, port B wins and port A is dropped.
- In CLEAR, wa_en and wb_en are ignored entirely.

Reads (combinational, independent per port). For port k, evaluate in priority order:
1. busy=1 -> 0
2. rd_addr_k == 0 -> 0
3. wb_en and wb_addr == rd_addr_k -> wb_data
4. wa_en and wa_addr == rd_addr_k -> wa_data
5. otherwise mem[rd_addr_k]

dbg_out:
- Combinational from stored contents; no bypass applied.
- Forced to 0 while busy=1.
- A DBGn parameter equal to 0 yields a nibble of 0.

Width rules:
- Data is stored and returned at exactly DATA_W bits; no truncation or extension.
- ptr is ADDR_W bits; it never wraps, because the exit condition is checked at DEPTH-1.

## Timing
- Read latency is 0 cycles. rd_data is valid in the same cycle as rd_addr, with write bypass applied.
- Write latency is 1 edge: data is visible from mem on the cycle after the write edge, and through bypass in the write cycle itself.
- Clear duration: after rst falls, busy stays 1 for exactly DEPTH-1 edges. It is 0 on the cycle after the edge that clears entry DEPTH-1. With DEPTH=32, that is 31 cycles.
- Reset values:
  - busy=1, ptr=1, state=CLEAR.
  - rd_data=0 and dbg_out=0 while busy.
  - Stored contents are undefined until cleared, but never observable because outputs are gated.
- rst asserted mid-clear restarts ptr at 1. Already-cleared entries stay 0.
- rst asserted in RUN cancels writes on that edge.
- The first write accepted after reset is on the edge where busy has already read 0 in that cycle.

## Test plan
- Reset/clear: rst=1 for 2 cycles, then 0 -> busy=1 for 31 cycles, then 0. All 31 registers then read 0, and dbg_out=0x0000.
- Basic write/read: A writes 0xDEADBEEF to r8, B writes 0x12345678 to r9. Next cycle, rd_addr={r8,r9,r0} -> 0xDEADBEEF, 0x12345678, 0; dbg_out=0x0F80 (DBG1=8 nibble F, DBG2=9 nibble 8).
- Same-address conflict: A=(r3, 0x1111), B=(r3, 0x2222) on the same edge. Same-cycle bypass and the next-cycle read of r3 both return 0x2222.
- Bypass and r0: write r11=0xA5 while reading r11 in the same cycle -> 0xA5 before the edge. Writing r0=0xFFFFFFFF -> r0 still reads 0.
- Writes during clear: wa_en=1 to r5=0x55 while busy=1 -> after the clear completes, r5 reads 0.
- Reset mid-clear: rst pulses at clear cycle 10 -> busy stays 1 for 31 cycles after the second rst falls; all entries read 0 afterwards.
